// File: rtl/fnn_loader_pkg.sv
// Shared types and header field positions for the FNN weight loader.
// The bias-load build option (macro FNN_BIAS_LOAD_EN) is consumed by fnn_weight_loader.
package fnn_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      WGT,
      BIAS,
      DONE
   } loadState_e;

   localparam int HDR_N_MSB = 31;
   localparam int HDR_N_LSB = 16;
   localparam int HDR_W_MSB = 15;
   localparam int HDR_W_LSB = 0;

endpackage

// File: rtl/fnn_weight_loader.sv
// Streams per-layer weight (and optionally bias) words onto the shared neuron configuration bus.
// Define FNN_BIAS_LOAD_EN to expect a trailing bias word per neuron and drive biasValid/biasValue.
module fnn_weight_loader
   import fnn_loader_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        weightValid,
   output logic [31:0] weightValue,
   output logic        biasValid,
   output logic [31:0] biasValue,
   output logic [31:0] config_layer_num,
   output logic [31:0] config_neuron_num,
   output logic        busy,
   output logic        done,
   output logic        err
);

   loadState_e state_q, state_d;
   logic [CNT_W-1:0] layer_q, layer_d;
   logic [CNT_W-1:0] neuron_q, neuron_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0] nTot_q, nTot_d;
   logic [CNT_W-1:0] wTot_q, wTot_d;
   logic             err_q, err_d;

   logic             weightValid_q;
   logic [31:0]      weightValue_q;
   logic [31:0]      cfgLayer_q;
   logic [31:0]      cfgNeuron_q;
   logic             done_q;

   logic [HDR_N_MSB-HDR_N_LSB:0] hdrN;
   logic [HDR_W_MSB-HDR_W_LSB:0] hdrW;
   logic             xfer;
   logic             wgtXfer;
   logic             biasXfer;
   logic             advance;
   logic             lastNeuron;
   logic             lastLayer;

   assign s_ready    = (state_q == HDR) || (state_q == WGT) || (state_q == BIAS);
   assign busy       = (state_q != IDLE);
   assign xfer       = s_valid && s_ready;
   assign wgtXfer    = xfer && (state_q == WGT);
   assign hdrN       = s_data[HDR_N_MSB:HDR_N_LSB];
   assign hdrW       = s_data[HDR_W_MSB:HDR_W_LSB];
   assign lastNeuron = (neuron_q == nTot_q - CNT_W'(1));
   assign lastLayer  = (layer_q == CNT_W'(NUM_LAYERS));

`ifdef FNN_BIAS_LOAD_EN
   assign biasXfer = xfer && (state_q == BIAS);
`else
   assign biasXfer = 1'b0;
`endif

   // State and counter registers; all cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         layer_q  <= '0;
         neuron_q <= '0;
         wcnt_q   <= '0;
         nTot_q   <= '0;
         wTot_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         neuron_q <= neuron_d;
         wcnt_q   <= wcnt_d;
         nTot_q   <= nTot_d;
         wTot_q   <= wTot_d;
         err_q    <= err_d;
      end
   end

   // Walks header -> weights (-> bias) per neuron, then rolls over to the next layer.
   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      neuron_d = neuron_q;
      wcnt_d   = wcnt_q;
      nTot_d   = nTot_q;
      wTot_d   = wTot_q;
      err_d    = err_q;
      advance  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = HDR;
               layer_d  = CNT_W'(1);
               neuron_d = '0;
               wcnt_d   = '0;
               err_d    = 1'b0;
            end
         end
         HDR: begin
            if (xfer) begin
               nTot_d = CNT_W'(hdrN);
               wTot_d = CNT_W'(hdrW);
               wcnt_d = '0;
               if ((hdrN == '0) || (hdrW == '0)) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WGT;
               end
            end
         end
         WGT: begin
            if (xfer) begin
               if (wcnt_q == wTot_q - CNT_W'(1)) begin
                  wcnt_d = '0;
`ifdef FNN_BIAS_LOAD_EN
                  state_d = BIAS;
`else
                  advance = 1'b1;
`endif
               end else begin
                  wcnt_d = wcnt_q + CNT_W'(1);
               end
            end
         end
`ifdef FNN_BIAS_LOAD_EN
         BIAS: begin
            if (xfer) begin
               advance = 1'b1;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (advance) begin
         if (lastNeuron) begin
            neuron_d = '0;
            if (lastLayer) begin
               state_d = DONE;
            end else begin
               layer_d = layer_q + CNT_W'(1);
               state_d = HDR;
            end
         end else begin
            neuron_d = neuron_q + CNT_W'(1);
            state_d  = WGT;
         end
      end
   end

   // Bus outputs are registered so each pulse lands exactly one cycle after its transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         weightValid_q <= 1'b0;
         weightValue_q <= '0;
         cfgLayer_q    <= '0;
         cfgNeuron_q   <= '0;
         done_q        <= 1'b0;
      end else begin
         weightValid_q <= wgtXfer;
         done_q        <= (state_q == DONE);
         if (wgtXfer) begin
            weightValue_q <= s_data;
         end
         if (wgtXfer || biasXfer) begin
            cfgLayer_q  <= 32'(layer_q);
            cfgNeuron_q <= 32'(neuron_q);
         end
      end
   end

`ifdef FNN_BIAS_LOAD_EN
   logic        biasValid_q;
   logic [31:0] biasValue_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         biasValid_q <= 1'b0;
         biasValue_q <= '0;
      end else begin
         biasValid_q <= biasXfer;
         if (biasXfer) begin
            biasValue_q <= s_data;
         end
      end
   end

   assign biasValid = biasValid_q;
   assign biasValue = biasValue_q;
`else
   assign biasValid = 1'b0;
   assign biasValue = '0;
`endif

   assign weightValid       = weightValid_q;
   assign weightValue       = weightValue_q;
   assign config_layer_num  = cfgLayer_q;
   assign config_neuron_num = cfgNeuron_q;
   assign done              = done_q;
   assign err               = err_q;

endmodule

// File: tb/tb_fnn_weight_loader.sv
// Scoreboard bench for fnn_weight_loader (two-layer build); follows FNN_BIAS_LOAD_EN for stream layout.
// Expected bus pulses are queued as words are transferred and checked when the DUT emits them.
module tb_fnn_weight_loader;

`ifdef FNN_BIAS_LOAD_EN
   localparam bit BiasOn = 1'b1;
`else
   localparam bit BiasOn = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        weightValid;
   logic [31:0] weightValue;
   logic        biasValid;
   logic [31:0] biasValue;
   logic [31:0] config_layer_num;
   logic [31:0] config_neuron_num;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct {
      int          kind;
      logic [31:0] val;
      int          lay;
      int          neu;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   nVec = 0;
   int   nErr = 0;
   int   cyc  = 0;

   fnn_weight_loader #(
      .NUM_LAYERS(2),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .weightValid(weightValid),
      .weightValue(weightValue),
      .biasValid(biasValid),
      .biasValue(biasValue),
      .config_layer_num(config_layer_num),
      .config_neuron_num(config_neuron_num),
      .busy(busy),
      .done(done),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every bus pulse must match the oldest queued expectation, one cycle after its transfer.
   always @(negedge clk) begin
      if (weightValid === 1'b1 && biasValid === 1'b1) begin
         nVec++;
         nErr++;
         $display("[TB] FAIL both_valid weightValid=%b biasValid=%b want not both", weightValid, biasValid);
      end else if (weightValid === 1'b1 || biasValid === 1'b1) begin
         nVec++;
         if (sb.size() == 0) begin
            nErr++;
            $display("[TB] FAIL unexpected_pulse wv=%b bv=%b at cyc %0d want none", weightValid, biasValid, cyc);
         end else begin
            exp_t e;
            int          gotKind;
            logic [31:0] gotVal;
            e = sb.pop_front();
            gotKind = weightValid ? 1 : 2;
            gotVal  = weightValid ? weightValue : biasValue;
            if (gotKind !== e.kind || gotVal !== e.val || config_layer_num !== 32'(e.lay) ||
                config_neuron_num !== 32'(e.neu) || cyc !== e.cyc) begin
               nErr++;
               $display("[TB] FAIL bus_pulse got kind=%0d val=%0h L=%0d N=%0d cyc=%0d want kind=%0d val=%0h L=%0d N=%0d cyc=%0d",
                        gotKind, gotVal, config_layer_num, config_neuron_num, cyc,
                        e.kind, e.val, e.lay, e.neu, e.cyc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout got no finish want finish");
      $fatal(1, "[TB] timeout");
   end

   // Drives one word, waits (bounded) for s_ready, and queues the bus pulse it should cause.
   task automatic applyStimulus(input logic [31:0] w, input int kind, input int lay, input int neu);
      int waitCyc = 0;
      s_data  = w;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && waitCyc < 50) begin
         @(posedge clk); #1;
         waitCyc++;
      end
      if (s_ready !== 1'b1) begin
         nVec++;
         nErr++;
         $display("[TB] FAIL s_ready_timeout got %b want 1", s_ready);
      end else if (kind != 0) begin
         sb.push_back('{kind, w, lay, neu, cyc + 1});
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data  = '0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic sendLayer(input logic [31:0] hdr, input int lay, inout int nextVal, input bit gaps);
      int n;
      int wn;
      n  = int'(hdr[31:16]);
      wn = int'(hdr[15:0]);
      applyStimulus(hdr, 0, 0, 0);
      for (int ne = 0; ne < n; ne++) begin
         for (int wi = 0; wi < wn; wi++) begin
            if (gaps) begin @(posedge clk); #1; end
            applyStimulus(32'(nextVal), 1, lay, ne);
            nextVal++;
         end
         if (BiasOn) begin
            if (gaps) begin @(posedge clk); #1; end
            applyStimulus(32'(nextVal), 2, lay, ne);
            nextVal++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      nVec++;
      if ({s_ready, weightValid, biasValid, busy, done, err} !== 6'b0 ||
          weightValue !== 32'h0 || biasValue !== 32'h0 ||
          config_layer_num !== 32'h0 || config_neuron_num !== 32'h0) begin
         nErr++;
         $display("[TB] FAIL reset_state got rdy=%b wv=%b bv=%b busy=%b done=%b err=%b wval=%0h bval=%0h L=%0h N=%0h want all 0",
                  s_ready, weightValid, biasValid, busy, done, err, weightValue, biasValue,
                  config_layer_num, config_neuron_num);
      end
   endtask

   task automatic test_load(input logic [31:0] h1, input logic [31:0] h2, input bit gaps, input string name);
      int v = 1;
      @(posedge clk); #1;
      pulseStart();
      nVec++;
      if (s_ready !== 1'b1 || busy !== 1'b1) begin
         nErr++;
         $display("[TB] FAIL %s_hdr1_ready got rdy=%b busy=%b want 1 1", name, s_ready, busy);
      end
      sendLayer(h1, 1, v, gaps);
      nVec++;
      if (s_ready !== 1'b1 || busy !== 1'b1) begin
         nErr++;
         $display("[TB] FAIL %s_hdr2_ready got rdy=%b busy=%b want 1 1", name, s_ready, busy);
      end
      sendLayer(h2, 2, v, gaps);
      @(negedge clk);
      nVec++;
      if (done !== 1'b0) begin
         nErr++;
         $display("[TB] FAIL %s_done_early got %b want 0", name, done);
      end
      @(negedge clk);
      nVec++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         nErr++;
         $display("[TB] FAIL %s_done got done=%b busy=%b want 1 0", name, done, busy);
      end
      @(negedge clk);
      nVec++;
      if (done !== 1'b0 || sb.size() != 0) begin
         nErr++;
         $display("[TB] FAIL %s_after_done got done=%b pending=%0d want 0 0", name, done, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      test_load(32'h0002_0003, 32'h0001_0001, 1'b0, "b2b");
   endtask

   task automatic test_gaps();
      test_load(32'h0002_0003, 32'h0001_0001, 1'b1, "gaps");
   endtask

   task automatic test_layers();
      test_load(32'h0001_0002, 32'h0002_0001, 1'b0, "layers");
   endtask

   task automatic test_bad_header();
      int sawDone = 0;
      @(posedge clk); #1;
      pulseStart();
      applyStimulus(32'h0000_0005, 0, 0, 0);
      nVec++;
      if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
         nErr++;
         $display("[TB] FAIL bad_hdr got err=%b busy=%b rdy=%b want 1 0 0", err, busy, s_ready);
      end
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) sawDone++;
      end
      nVec++;
      if (sawDone != 0 || err !== 1'b1) begin
         nErr++;
         $display("[TB] FAIL bad_hdr_no_done got done_cycles=%0d err=%b want 0 1", sawDone, err);
      end
      @(posedge clk); #1;
      pulseStart();
      nVec++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         nErr++;
         $display("[TB] FAIL bad_hdr_restart got err=%b busy=%b want 0 1", err, busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset_midload();
      int sawPulse = 0;
      @(posedge clk); #1;
      pulseStart();
      applyStimulus(32'h0002_0003, 0, 0, 0);
      applyStimulus(32'h0000_0011, 1, 1, 0);
      applyStimulus(32'h0000_0022, 1, 1, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      nVec++;
      if ({s_ready, weightValid, biasValid, busy, done, err} !== 6'b0 ||
          weightValue !== 32'h0 || biasValue !== 32'h0 ||
          config_layer_num !== 32'h0 || config_neuron_num !== 32'h0) begin
         nErr++;
         $display("[TB] FAIL midload_reset got rdy=%b wv=%b busy=%b wval=%0h L=%0h N=%0h want all 0",
                  s_ready, weightValid, busy, weightValue, config_layer_num, config_neuron_num);
      end
      s_valid = 1'b1;
      s_data  = 32'h0000_0033;
      repeat (3) begin
         @(negedge clk);
         if (weightValid === 1'b1 || s_ready === 1'b1) sawPulse++;
      end
      s_valid = 1'b0;
      s_data  = '0;
      nVec++;
      if (sawPulse != 0) begin
         nErr++;
         $display("[TB] FAIL midload_idle got active_cycles=%0d want 0", sawPulse);
      end
   endtask

   task automatic test_start_while_busy();
      int v = 100;
      @(posedge clk); #1;
      pulseStart();
      applyStimulus(32'h0001_0002, 0, 0, 0);
      start = 1'b1;
      applyStimulus(32'(v), 1, 1, 0);
      v++;
      start = 1'b0;
      nVec++;
      if (busy !== 1'b1 || s_ready !== 1'b1 || err !== 1'b0) begin
         nErr++;
         $display("[TB] FAIL start_busy got busy=%b rdy=%b err=%b want 1 1 0", busy, s_ready, err);
      end
      applyStimulus(32'(v), 1, 1, 0);
      v++;
      if (BiasOn) begin
         applyStimulus(32'(v), 2, 1, 0);
         v++;
      end
      sendLayer(32'h0001_0001, 2, v, 1'b0);
      @(negedge clk);
      @(negedge clk);
      nVec++;
      if (done !== 1'b1) begin
         nErr++;
         $display("[TB] FAIL start_busy_done got %b want 1", done);
      end
   endtask

   initial begin
      $display("[TB] start, bias load %0s", BiasOn ? "enabled" : "disabled");
      test_reset();
      test_back_to_back();
      test_gaps();
      test_layers();
      test_bad_header();
      test_reset_midload();
      test_start_while_busy();
      repeat (4) @(negedge clk);
      nVec++;
      if (sb.size() != 0) begin
         nErr++;
         $display("[TB] FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
